// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM encoding and fetch constants.
package pipe_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/ifu_perf_ctr.sv
// Enable-gated 32-bit wrapping event counter.
module ifu_perf_ctr (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    cnt <= '0;
        else if (en) cnt <= cnt + 32'd1;
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding word fetch, one-entry output buffer.
// Optional IFU_PERF_EN adds fetch / wait-cycle performance counters.
module ifu_fetch
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              resp_valid,
    input  logic [31:0]       resp_data,
    input  logic              resp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_inst,
    output logic              out_fault
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_wait_cnt
`endif
);

    fetch_state_e      state, state_n;
    logic              drop, drop_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic              load, consume;

    assign req_addr = pc;
    assign load     = (state == WAIT) && resp_valid && !drop && !flush;
    assign consume  = (state == HOLD) && out_ready && !flush;

    always_comb begin
        state_n = state;
        drop_n  = drop;
        pc_n    = pc;
        case (state)
            FETCH: if (req_valid && req_ready) state_n = WAIT;
            WAIT: if (resp_valid) begin
                drop_n  = 1'b0;
                state_n = drop ? FETCH : HOLD;
            end
            HOLD: if (out_ready) state_n = FETCH;
            default: state_n = FETCH;
        endcase
        if (consume) pc_n = pc + PC_INC[ADDR_W-1:0];
        // A redirect may leave one request in flight; drop marks its response as stale.
        if (flush) begin
            pc_n = {redirect_pc[ADDR_W-1:2], 2'b00};
            if (state == FETCH && req_valid && req_ready) begin
                state_n = WAIT;
                drop_n  = 1'b1;
            end else if (state == WAIT && !resp_valid) begin
                state_n = WAIT;
                drop_n  = 1'b1;
            end else begin
                state_n = FETCH;
                drop_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            drop      <= 1'b0;
            pc        <= RESET_PC[ADDR_W-1:0];
            req_valid <= 1'b0;
            out_valid <= 1'b0;
            out_pc    <= RESET_PC[ADDR_W-1:0];
            out_inst  <= INST_NOP;
            out_fault <= 1'b0;
        end else begin
            state     <= state_n;
            drop      <= drop_n;
            pc        <= pc_n;
            req_valid <= (state_n == FETCH);
            if (flush)        out_valid <= 1'b0;
            else if (load)    out_valid <= 1'b1;
            else if (consume) out_valid <= 1'b0;
            if (load) begin
                out_pc    <= pc;
                out_inst  <= resp_data;
                out_fault <= resp_err;
            end
        end
    end

`ifdef IFU_PERF_EN
    ifu_perf_ctr u_fetch_ctr (
        .clk (clk),
        .rst (rst),
        .en  (out_valid && out_ready && !flush),
        .cnt (perf_fetch_cnt)
    );

    ifu_perf_ctr u_wait_ctr (
        .clk (clk),
        .rst (rst),
        .en  (state == WAIT),
        .cnt (perf_wait_cnt)
    );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a behavioural single-outstanding memory.
module tb_ifu_fetch;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready, out_valid, out_ready, out_fault;
    logic        resp_valid = 1'b0, resp_err = 1'b0;
    logic [31:0] redirect_pc, req_addr, out_pc, out_inst;
    logic [31:0] resp_data = 32'h0;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_wait_cnt;
`endif

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_fault   (out_fault)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory: accepts on posedge, answers lat cycles later; data = {addr[15:0], 16'h0013}.
    int          lat = 1;
    logic [31:0] err_addr = 32'h0000_0001;
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] acc_q[$];
    logic [31:0] dpc_q[$];

    always @(posedge clk) begin
        if (rst && req_valid && req_ready) begin
            acc_q.push_back(req_addr);
            pend  = 1'b1;
            paddr = req_addr;
            pcnt  = lat;
        end
        if (rst && out_valid && out_ready && !flush) dpc_q.push_back(out_pc);
    end

    always @(negedge clk) begin
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
                resp_valid = 1'b1;
                resp_data  = {paddr[15:0], 16'h0013};
                resp_err   = (paddr == err_addr);
                pend       = 1'b0;
            end
        end
    end

    task automatic wait_ov(input string tag);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        chk(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic pulse_ready();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush       = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        flush       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic stable;
        rst = 1'b0; flush = 1'b0; redirect_pc = 32'h0; req_ready = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'h3000_0000);
        chk("rst_out_inst", out_inst, 32'h0000_0013);
        chk("rst_out_fault", 32'(out_fault), 32'd0);
        rst = 1'b1;

        // Streaming with a 1-cycle memory
        for (int i = 0; i < 60 && dpc_q.size() < 3; i++) @(negedge clk);
        out_ready = 1'b0;
        chk("seq_cnt", 32'(dpc_q.size()), 32'd3);
        chk("seq_acc0", acc_q[0], 32'h3000_0000);
        chk("seq_acc1", acc_q[1], 32'h3000_0004);
        chk("seq_acc2", acc_q[2], 32'h3000_0008);
        chk("seq_dpc2", dpc_q[2], 32'h3000_0008);

        // Back-pressure in HOLD
        wait_ov("hold_valid");
        n = acc_q.size();
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || out_pc != 32'h3000_000C || out_inst != 32'h000C_0013 || req_valid)
                stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        chk("hold_pc", out_pc, 32'h3000_000C);
        chk("hold_inst", out_inst, 32'h000C_0013);
        chk("hold_nofetch", 32'(acc_q.size()), 32'(n));
        pulse_ready();
        chk("hold_consumed", 32'(dpc_q.size()), 32'd4);

        // Flush beats out_ready in HOLD
        wait_ov("hf_valid");
        chk("hf_pc_before", out_pc, 32'h3000_0010);
        out_ready = 1'b1;
        do_flush(32'h3000_0040);
        out_ready = 1'b0;
        chk("hf_nodeliver", 32'(dpc_q.size()), 32'd4);
        chk("hf_ov_low", 32'(out_valid), 32'd0);
        wait_ov("hf_valid2");
        chk("hf_pc", out_pc, 32'h3000_0040);
        chk("hf_acc", acc_q[$], 32'h3000_0040);

        // Flush while WAIT, stale response 3 cycles later
        lat = 3;
        n = acc_q.size();
        pulse_ready();
        for (int i = 0; i < 20 && acc_q.size() == n; i++) @(negedge clk);
        do_flush(32'h8000_0102);
        wait_ov("fw_valid");
        chk("fw_pc", out_pc, 32'h8000_0100);
        chk("fw_inst", out_inst, 32'h0100_0013);
        chk("fw_acc_cnt", 32'(acc_q.size()), 32'(n + 2));
        chk("fw_acc_new", acc_q[$], 32'h8000_0100);
        lat = 1;

        // Bus error is delivered, not stalled
        err_addr = 32'h3000_0020;
        do_flush(32'h3000_0020);
        wait_ov("err_valid");
        chk("err_pc", out_pc, 32'h3000_0020);
        chk("err_fault", 32'(out_fault), 32'd1);
        pulse_ready();
        wait_ov("err_next_valid");
        chk("err_next_pc", out_pc, 32'h3000_0024);
        chk("err_next_fault", 32'(out_fault), 32'd0);

        // PC wrap
        do_flush(32'hFFFF_FFFE);
        wait_ov("wrap_valid");
        chk("wrap_pc_top", out_pc, 32'hFFFF_FFFC);
        pulse_ready();
        wait_ov("wrap_valid2");
        chk("wrap_pc_zero", out_pc, 32'h0000_0000);
        chk("wrap_acc", acc_q[$], 32'h0000_0000);
`ifdef IFU_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 32'(dpc_q.size()));
        chk("perf_wait_nz", 32'(perf_wait_cnt != 32'd0), 32'd1);
`endif

        // Flush in FETCH coincident with acceptance: stale response must be dropped
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ff_req_valid", 32'(req_valid), 32'd1);
        do_flush(32'h4000_0008);
        wait_ov("ff_valid");
        chk("ff_pc", out_pc, 32'h4000_0008);
        chk("ff_inst", out_inst, 32'h0008_0013);
        chk("ff_stale_acc", acc_q[$-1], 32'h0000_0004);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
